// File: rtl/control_pkg.sv
// Shared definitions for the Mini SRC hardwired control unit.
// Holds the opcode encodings, the bit positions of every datapath control
// signal inside the packed ctrl vector, and the sequencer state type.
// Two helpers are also defined here: the ALU operation select for an opcode,
// and the last execute T-step for an opcode.
package control_pkg;

  localparam int unsigned CTRL_BITS = 42;
  localparam int unsigned OPC_BITS  = 5;

  // Opcodes, IR[31:27]
  localparam logic [OPC_BITS-1:0] OP_LD   = 5'b00000;
  localparam logic [OPC_BITS-1:0] OP_LDI  = 5'b00001;
  localparam logic [OPC_BITS-1:0] OP_ST   = 5'b00010;
  localparam logic [OPC_BITS-1:0] OP_ADD  = 5'b00011;
  localparam logic [OPC_BITS-1:0] OP_SUB  = 5'b00100;
  localparam logic [OPC_BITS-1:0] OP_AND  = 5'b00101;
  localparam logic [OPC_BITS-1:0] OP_OR   = 5'b00110;
  localparam logic [OPC_BITS-1:0] OP_ROR  = 5'b00111;
  localparam logic [OPC_BITS-1:0] OP_ROL  = 5'b01000;
  localparam logic [OPC_BITS-1:0] OP_SHR  = 5'b01001;
  localparam logic [OPC_BITS-1:0] OP_SHRA = 5'b01010;
  localparam logic [OPC_BITS-1:0] OP_SHL  = 5'b01011;
  localparam logic [OPC_BITS-1:0] OP_ADDI = 5'b01100;
  localparam logic [OPC_BITS-1:0] OP_ANDI = 5'b01101;
  localparam logic [OPC_BITS-1:0] OP_ORI  = 5'b01110;
  localparam logic [OPC_BITS-1:0] OP_DIV  = 5'b01111;
  localparam logic [OPC_BITS-1:0] OP_MUL  = 5'b10000;
  localparam logic [OPC_BITS-1:0] OP_NEG  = 5'b10001;
  localparam logic [OPC_BITS-1:0] OP_NOT  = 5'b10010;
  localparam logic [OPC_BITS-1:0] OP_BR   = 5'b10011;
  localparam logic [OPC_BITS-1:0] OP_JR   = 5'b10100;
  localparam logic [OPC_BITS-1:0] OP_JAL  = 5'b10101;
  localparam logic [OPC_BITS-1:0] OP_IN   = 5'b10110;
  localparam logic [OPC_BITS-1:0] OP_OUT  = 5'b10111;
  localparam logic [OPC_BITS-1:0] OP_MFHI = 5'b11000;
  localparam logic [OPC_BITS-1:0] OP_MFLO = 5'b11001;
  localparam logic [OPC_BITS-1:0] OP_NOP  = 5'b11010;
  localparam logic [OPC_BITS-1:0] OP_HALT = 5'b11011;

  // Bit positions inside ctrl
  localparam int unsigned B_HI_IN      = 0;
  localparam int unsigned B_LO_IN      = 1;
  localparam int unsigned B_HI_OUT     = 2;
  localparam int unsigned B_LO_OUT     = 3;
  localparam int unsigned B_ZHIGH_IN   = 4;
  localparam int unsigned B_ZLOW_IN    = 5;
  localparam int unsigned B_ZHIGH_OUT  = 6;
  localparam int unsigned B_ZLOW_OUT   = 7;
  localparam int unsigned B_PC_IN      = 8;
  localparam int unsigned B_PC_OUT     = 9;
  localparam int unsigned B_MDR_IN     = 10;
  localparam int unsigned B_MDR_OUT    = 11;
  localparam int unsigned B_MAR_IN     = 12;
  localparam int unsigned B_INPORT_OUT = 13;
  localparam int unsigned B_OUTPORT_IN = 14;
  localparam int unsigned B_CSE_OUT    = 15;
  localparam int unsigned B_IR_IN      = 16;
  localparam int unsigned B_MDMUX_READ = 17;
  localparam int unsigned B_Y_IN       = 18;
  localparam int unsigned B_ADD        = 19;
  localparam int unsigned B_SUB        = 20;
  localparam int unsigned B_MUL        = 21;
  localparam int unsigned B_DIV        = 22;
  localparam int unsigned B_AND        = 23;
  localparam int unsigned B_OR         = 24;
  localparam int unsigned B_SHR        = 25;
  localparam int unsigned B_SHRA       = 26;
  localparam int unsigned B_SHL        = 27;
  localparam int unsigned B_ROR        = 28;
  localparam int unsigned B_ROL        = 29;
  localparam int unsigned B_NEG        = 30;
  localparam int unsigned B_NOT        = 31;
  localparam int unsigned B_INC_PC     = 32;
  localparam int unsigned B_GRA        = 33;
  localparam int unsigned B_GRB        = 34;
  localparam int unsigned B_GRC        = 35;
  localparam int unsigned B_RIN        = 36;
  localparam int unsigned B_ROUT       = 37;
  localparam int unsigned B_BA_OUT     = 38;
  localparam int unsigned B_RAM_READ   = 39;
  localparam int unsigned B_RAM_WRITE  = 40;
  localparam int unsigned B_CON_IN     = 41;

  // T-steps share their numeric value with the step index so tstep is a slice.
  typedef enum logic [3:0] {
    S_T0    = 4'd0,
    S_T1    = 4'd1,
    S_T2    = 4'd2,
    S_T3    = 4'd3,
    S_T4    = 4'd4,
    S_T5    = 4'd5,
    S_T6    = 4'd6,
    S_T7    = 4'd7,
    S_RESET = 4'd8,
    S_HALT  = 4'd9
  } state_t;

  // One-hot ALU select for register/immediate/multiply/unary opcodes.
  function automatic logic [CTRL_BITS-1:0] alu_op_mask(input logic [OPC_BITS-1:0] opc);
    logic [CTRL_BITS-1:0] m;
    m = '0;
    case (opc)
      OP_ADD, OP_ADDI: m[B_ADD]  = 1'b1;
      OP_SUB:          m[B_SUB]  = 1'b1;
      OP_AND, OP_ANDI: m[B_AND]  = 1'b1;
      OP_OR,  OP_ORI:  m[B_OR]   = 1'b1;
      OP_ROR:          m[B_ROR]  = 1'b1;
      OP_ROL:          m[B_ROL]  = 1'b1;
      OP_SHR:          m[B_SHR]  = 1'b1;
      OP_SHRA:         m[B_SHRA] = 1'b1;
      OP_SHL:          m[B_SHL]  = 1'b1;
      OP_DIV:          m[B_DIV]  = 1'b1;
      OP_MUL:          m[B_MUL]  = 1'b1;
      OP_NEG:          m[B_NEG]  = 1'b1;
      OP_NOT:          m[B_NOT]  = 1'b1;
      default:         m = '0;
    endcase
    return m;
  endfunction

  // Final step of each instruction; nop and unused opcodes end after fetch.
  function automatic state_t last_step(input logic [OPC_BITS-1:0] opc);
    state_t s;
    case (opc)
      OP_LD, OP_ST:                                   s = S_T7;
      OP_LDI, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR,
      OP_ROL, OP_SHR, OP_SHRA, OP_SHL, OP_ADDI,
      OP_ANDI, OP_ORI:                                s = S_T5;
      OP_DIV, OP_MUL, OP_BR:                          s = S_T6;
      OP_NEG, OP_NOT, OP_JAL:                         s = S_T4;
      OP_JR, OP_IN, OP_OUT, OP_MFHI, OP_MFLO, OP_HALT: s = S_T3;
      default:                                        s = S_T2;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/control_sequencer_ctrl_decode.sv
// ctrl_decode: combinational map from sequencer state, opcode and ConFFQ to
// the packed datapath control vector.
// Ports:
//   state   - current sequencer state
//   opcode  - IR[31:27]
//   con_ffq - branch condition, only gates PCin in br T6
//   ctrl    - packed control signals (bit map in control_pkg)
module ctrl_decode
  import control_pkg::*;
(
  input  state_t               state,
  input  logic [OPC_BITS-1:0]  opcode,
  input  logic                 con_ffq,
  output logic [CTRL_BITS-1:0] ctrl
);

  logic [CTRL_BITS-1:0] op_mask;

  always_comb begin
    op_mask = alu_op_mask(opcode);
    ctrl    = '0;
    case (state)
      S_T0: begin
        ctrl[B_PC_OUT] = 1'b1; ctrl[B_MAR_IN] = 1'b1;
        ctrl[B_INC_PC] = 1'b1; ctrl[B_ZLOW_IN] = 1'b1;
      end
      S_T1: begin
        ctrl[B_ZLOW_OUT] = 1'b1; ctrl[B_PC_IN] = 1'b1; ctrl[B_MDMUX_READ] = 1'b1;
        ctrl[B_RAM_READ] = 1'b1; ctrl[B_MDR_IN] = 1'b1;
      end
      S_T2: begin
        ctrl[B_MDR_OUT] = 1'b1; ctrl[B_IR_IN] = 1'b1;
      end
      S_T3, S_T4, S_T5, S_T6, S_T7: begin
        case (opcode)
          OP_LD, OP_LDI, OP_ST: begin
            case (state)
              S_T3: begin ctrl[B_GRB] = 1'b1; ctrl[B_BA_OUT] = 1'b1; ctrl[B_Y_IN] = 1'b1; end
              S_T4: begin ctrl[B_CSE_OUT] = 1'b1; ctrl[B_ADD] = 1'b1; ctrl[B_ZLOW_IN] = 1'b1; end
              S_T5: begin
                ctrl[B_ZLOW_OUT] = 1'b1;
                if (opcode == OP_LDI) begin
                  ctrl[B_GRA] = 1'b1; ctrl[B_RIN] = 1'b1;
                end else begin
                  ctrl[B_MAR_IN] = 1'b1;
                end
              end
              S_T6: begin
                ctrl[B_MDR_IN] = 1'b1;
                if (opcode == OP_LD) begin
                  ctrl[B_MDMUX_READ] = 1'b1; ctrl[B_RAM_READ] = 1'b1;
                end else if (opcode == OP_ST) begin
                  ctrl[B_GRA] = 1'b1; ctrl[B_ROUT] = 1'b1;
                end else begin
                  ctrl[B_MDR_IN] = 1'b0;
                end
              end
              S_T7: begin
                if (opcode == OP_LD) begin
                  ctrl[B_MDR_OUT] = 1'b1; ctrl[B_GRA] = 1'b1; ctrl[B_RIN] = 1'b1;
                end else if (opcode == OP_ST) begin
                  ctrl[B_RAM_WRITE] = 1'b1;
                end
              end
              default: ;
            endcase
          end
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL, OP_SHR, OP_SHRA, OP_SHL,
          OP_ADDI, OP_ANDI, OP_ORI: begin
            case (state)
              S_T3: begin ctrl[B_GRB] = 1'b1; ctrl[B_ROUT] = 1'b1; ctrl[B_Y_IN] = 1'b1; end
              S_T4: begin
                // Register form takes the second operand from Rc, immediate form from C.
                ctrl = ctrl | op_mask;
                ctrl[B_ZLOW_IN] = 1'b1;
                if (opcode inside {OP_ADDI, OP_ANDI, OP_ORI}) begin
                  ctrl[B_CSE_OUT] = 1'b1;
                end else begin
                  ctrl[B_GRC] = 1'b1; ctrl[B_ROUT] = 1'b1;
                end
              end
              S_T5: begin ctrl[B_ZLOW_OUT] = 1'b1; ctrl[B_GRA] = 1'b1; ctrl[B_RIN] = 1'b1; end
              default: ;
            endcase
          end
          OP_DIV, OP_MUL: begin
            case (state)
              S_T3: begin ctrl[B_GRA] = 1'b1; ctrl[B_ROUT] = 1'b1; ctrl[B_Y_IN] = 1'b1; end
              S_T4: begin
                ctrl = ctrl | op_mask;
                ctrl[B_GRB] = 1'b1; ctrl[B_ROUT] = 1'b1;
                ctrl[B_ZLOW_IN] = 1'b1; ctrl[B_ZHIGH_IN] = 1'b1;
              end
              S_T5: begin ctrl[B_ZLOW_OUT] = 1'b1; ctrl[B_LO_IN] = 1'b1; end
              S_T6: begin ctrl[B_ZHIGH_OUT] = 1'b1; ctrl[B_HI_IN] = 1'b1; end
              default: ;
            endcase
          end
          OP_NEG, OP_NOT: begin
            case (state)
              S_T3: begin
                ctrl = ctrl | op_mask;
                ctrl[B_GRB] = 1'b1; ctrl[B_ROUT] = 1'b1; ctrl[B_ZLOW_IN] = 1'b1;
              end
              S_T4: begin ctrl[B_ZLOW_OUT] = 1'b1; ctrl[B_GRA] = 1'b1; ctrl[B_RIN] = 1'b1; end
              default: ;
            endcase
          end
          OP_BR: begin
            case (state)
              S_T3: begin ctrl[B_GRA] = 1'b1; ctrl[B_ROUT] = 1'b1; ctrl[B_CON_IN] = 1'b1; end
              S_T4: begin ctrl[B_PC_OUT] = 1'b1; ctrl[B_Y_IN] = 1'b1; end
              S_T5: begin ctrl[B_CSE_OUT] = 1'b1; ctrl[B_ADD] = 1'b1; ctrl[B_ZLOW_IN] = 1'b1; end
              S_T6: begin ctrl[B_ZLOW_OUT] = 1'b1; ctrl[B_PC_IN] = con_ffq; end
              default: ;
            endcase
          end
          OP_JR: begin
            if (state == S_T3) begin
              ctrl[B_GRA] = 1'b1; ctrl[B_ROUT] = 1'b1; ctrl[B_PC_IN] = 1'b1;
            end
          end
          OP_JAL: begin
            if (state == S_T3) begin
              ctrl[B_PC_OUT] = 1'b1; ctrl[B_GRB] = 1'b1; ctrl[B_RIN] = 1'b1;
            end else if (state == S_T4) begin
              ctrl[B_GRA] = 1'b1; ctrl[B_ROUT] = 1'b1; ctrl[B_PC_IN] = 1'b1;
            end
          end
          OP_IN: begin
            if (state == S_T3) begin
              ctrl[B_INPORT_OUT] = 1'b1; ctrl[B_GRA] = 1'b1; ctrl[B_RIN] = 1'b1;
            end
          end
          OP_OUT: begin
            if (state == S_T3) begin
              ctrl[B_GRA] = 1'b1; ctrl[B_ROUT] = 1'b1; ctrl[B_OUTPORT_IN] = 1'b1;
            end
          end
          OP_MFHI: begin
            if (state == S_T3) begin
              ctrl[B_HI_OUT] = 1'b1; ctrl[B_GRA] = 1'b1; ctrl[B_RIN] = 1'b1;
            end
          end
          OP_MFLO: begin
            if (state == S_T3) begin
              ctrl[B_LO_OUT] = 1'b1; ctrl[B_GRA] = 1'b1; ctrl[B_RIN] = 1'b1;
            end
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: hardwired T-step control unit for the Mini SRC datapath.
// Runs fetch T0-T2 then the opcode's execute steps, returning to T0 or, when
// Stop is high at the final step, to HALT.
// Ports:
//   clock  - system clock, rising edge
//   clear  - asynchronous active-high reset to RESET
//   IR     - instruction register (opcode in [31:27])
//   ConFFQ - branch condition flip-flop output
//   Stop   - halt request, honoured at the end of the current instruction
//   ctrl   - packed datapath control vector
//   Run    - high while sequencing
//   tstep  - current T-step index, 0 in RESET/HALT
module control_sequencer
  import control_pkg::*;
#(
  parameter int unsigned CTRL_W = CTRL_BITS,
  parameter int unsigned OPC_W  = OPC_BITS
) (
  input  logic              clock,
  input  logic              clear,
  input  logic [31:0]       IR,
  input  logic              ConFFQ,
  input  logic              Stop,
  output logic [CTRL_W-1:0] ctrl,
  output logic              Run,
  output logic [3:0]        tstep
);

  state_t               state_q, state_d;
  logic                 run_q, run_d;
  logic [3:0]           tstep_q, tstep_d;
  logic [OPC_W-1:0]     opcode;
  logic [CTRL_BITS-1:0] ctrl_dec;
  logic                 ir_unused;

  assign opcode    = IR[31 -: OPC_W];
  assign ir_unused = ^IR[31-OPC_W:0];

  // IR is decoded directly (not through a register) because it only
  // becomes valid at the start of T3.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RESET: state_d = S_T0;
      S_HALT:  state_d = S_HALT;
      S_T0:    state_d = S_T1;
      S_T1:    state_d = S_T2;
      default: begin
        if (state_q == S_T3 && opcode == OP_HALT) begin
          state_d = S_HALT;
        end else if (state_q == last_step(opcode)) begin
          state_d = Stop ? S_HALT : S_T0;
        end else begin
          state_d = state_t'(state_q + 4'd1);
        end
      end
    endcase
    run_d   = !(state_d inside {S_RESET, S_HALT});
    tstep_d = run_d ? {1'b0, state_d[2:0]} : '0;
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q <= S_RESET;
      run_q   <= 1'b0;
      tstep_q <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      tstep_q <= tstep_d;
    end
  end

  ctrl_decode u_decode (
    .state   (state_q),
    .opcode  (opcode),
    .con_ffq (ConFFQ),
    .ctrl    (ctrl_dec)
  );

  assign ctrl  = ctrl_dec;
  assign Run   = run_q;
  assign tstep = tstep_q;

endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;

  logic        clock;
  logic        clear;
  logic [31:0] IR;
  logic        ConFFQ;
  logic        Stop;
  logic [41:0] ctrl;
  logic        Run;
  logic [3:0]  tstep;

  int checks;
  int failures;

  localparam logic [41:0] ONE = 42'd1;
  localparam logic [41:0] HIin = ONE << 0,  LOin = ONE << 1,  HIout = ONE << 2,  LOout = ONE << 3;
  localparam logic [41:0] Zhighin = ONE << 4, Zlowin = ONE << 5, Zhighout = ONE << 6, Zlowout = ONE << 7;
  localparam logic [41:0] PCin = ONE << 8, PCout = ONE << 9, MDRin = ONE << 10, MDRout = ONE << 11;
  localparam logic [41:0] MARin = ONE << 12, CSEout = ONE << 15, IRin = ONE << 16;
  localparam logic [41:0] MDMuxread = ONE << 17, Yin = ONE << 18, ADDb = ONE << 19, DIVb = ONE << 22;
  localparam logic [41:0] IncPC = ONE << 32, Gra = ONE << 33, Grb = ONE << 34, Grc = ONE << 35;
  localparam logic [41:0] Rin = ONE << 36, Rout = ONE << 37, BAout = ONE << 38;
  localparam logic [41:0] RAMread = ONE << 39, RAMwrite = ONE << 40, CONin = ONE << 41;
  localparam logic [41:0] OP_BITS = ((ONE << 13) - ONE) << 19;

  localparam logic [41:0] F0 = PCout | MARin | IncPC | Zlowin;
  localparam logic [41:0] F1 = Zlowout | PCin | MDMuxread | RAMread | MDRin;
  localparam logic [41:0] F2 = MDRout | IRin;

  control_sequencer #(.CTRL_W(42), .OPC_W(5)) dut (
    .clock  (clock),
    .clear  (clear),
    .IR     (IR),
    .ConFFQ (ConFFQ),
    .Stop   (Stop),
    .ctrl   (ctrl),
    .Run    (Run),
    .tstep  (tstep)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // No step may drive two ALU operations at once.
  always @(negedge clock) begin
    if (!clear) begin
      checks++;
      if ($countones(ctrl & OP_BITS) > 1) begin
        failures++;
        $display("FAIL op_onehot: ctrl=%h has %0d op bits, required at most 1", ctrl, $countones(ctrl & OP_BITS));
      end
    end
  end

  task automatic test_reset();
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if (ctrl !== 42'd0 || Run !== 1'b0 || tstep !== 4'd0) begin
      failures++;
      $display("FAIL reset: ctrl=%h Run=%b tstep=%0d, required ctrl=0 Run=0 tstep=0", ctrl, Run, tstep);
    end
    @(negedge clock);
    clear = 1'b0;
  endtask

  task automatic test_fetch_ldi();
    logic [41:0] exp [6];
    exp = '{F0, F1, F2, Grb | BAout | Yin, CSEout | ADDb | Zlowin, Zlowout | Gra | Rin};
    for (int i = 0; i < 6; i++) begin
      @(posedge clock); #1;
      checks++;
      if (ctrl !== exp[i] || tstep !== 4'(i) || Run !== 1'b1) begin
        failures++;
        $display("FAIL ldi step %0d: ctrl=%h tstep=%0d Run=%b, required ctrl=%h tstep=%0d Run=1", i, ctrl, tstep, Run, exp[i], i);
      end
      if (i == 0) IR = 32'h0B0000F1;
    end
  endtask

  task automatic test_jal_jr();
    logic [41:0] exp_jal [5];
    logic [41:0] exp_jr [4];
    exp_jal = '{F0, F1, F2, PCout | Grb | Rin, Gra | Rout | PCin};
    exp_jr  = '{F0, F1, F2, Gra | Rout | PCin};
    for (int i = 0; i < 5; i++) begin
      @(posedge clock); #1;
      checks++;
      if (ctrl !== exp_jal[i] || tstep !== 4'(i) || Run !== 1'b1) begin
        failures++;
        $display("FAIL jal step %0d: ctrl=%h tstep=%0d Run=%b, required ctrl=%h tstep=%0d", i, ctrl, tstep, Run, exp_jal[i], i);
      end
      if (i == 0) IR = 32'hAB000000;
    end
    for (int i = 0; i < 4; i++) begin
      @(posedge clock); #1;
      checks++;
      if (ctrl !== exp_jr[i] || tstep !== 4'(i) || Run !== 1'b1) begin
        failures++;
        $display("FAIL jr step %0d: ctrl=%h tstep=%0d Run=%b, required ctrl=%h tstep=%0d", i, ctrl, tstep, Run, exp_jr[i], i);
      end
      if (i == 0) IR = 32'hA7800000;
    end
  endtask

  task automatic test_br();
    logic [41:0] exp [7];
    for (int r = 0; r < 2; r++) begin
      exp = '{F0, F1, F2, Gra | Rout | CONin, PCout | Yin, CSEout | ADDb | Zlowin,
              Zlowout | ((r == 1) ? PCin : 42'd0)};
      for (int i = 0; i < 7; i++) begin
        @(posedge clock); #1;
        checks++;
        if (ctrl !== exp[i] || tstep !== 4'(i) || Run !== 1'b1) begin
          failures++;
          $display("FAIL br con=%0d step %0d: ctrl=%h tstep=%0d, required ctrl=%h tstep=%0d", r, i, ctrl, tstep, exp[i], i);
        end
        if (i == 0) begin
          IR     = 32'h98000000;
          ConFFQ = (r == 1);
        end
      end
    end
    ConFFQ = 1'b0;
  endtask

  task automatic test_div_nop();
    logic [41:0] exp_div [7];
    logic [41:0] exp_nop [3];
    exp_div = '{F0, F1, F2, Gra | Rout | Yin, Grb | Rout | DIVb | Zlowin | Zhighin,
                Zlowout | LOin, Zhighout | HIin};
    exp_nop = '{F0, F1, F2};
    for (int i = 0; i < 7; i++) begin
      @(posedge clock); #1;
      checks++;
      if (ctrl !== exp_div[i] || tstep !== 4'(i) || Run !== 1'b1) begin
        failures++;
        $display("FAIL div step %0d: ctrl=%h tstep=%0d, required ctrl=%h tstep=%0d", i, ctrl, tstep, exp_div[i], i);
      end
      if (i == 0) IR = 32'h78000000;
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      checks++;
      if (ctrl !== exp_nop[i] || tstep !== 4'(i) || Run !== 1'b1) begin
        failures++;
        $display("FAIL nop step %0d: ctrl=%h tstep=%0d, required ctrl=%h tstep=%0d", i, ctrl, tstep, exp_nop[i], i);
      end
      if (i == 0) IR = 32'hD0000000;
    end
  endtask

  task automatic test_reset_mid_ld();
    logic [41:0] exp [7];
    exp = '{F0, F1, F2, Grb | BAout | Yin, CSEout | ADDb | Zlowin, Zlowout | MARin,
            MDMuxread | RAMread | MDRin};
    for (int i = 0; i < 7; i++) begin
      @(posedge clock); #1;
      checks++;
      if (ctrl !== exp[i] || tstep !== 4'(i) || Run !== 1'b1) begin
        failures++;
        $display("FAIL ld step %0d: ctrl=%h tstep=%0d, required ctrl=%h tstep=%0d", i, ctrl, tstep, exp[i], i);
      end
      if (i == 0) IR = 32'h00000000;
    end
    #2 clear = 1'b1;
    #1;
    checks++;
    if (ctrl !== 42'd0 || tstep !== 4'd0 || Run !== 1'b0) begin
      failures++;
      $display("FAIL async_clear: ctrl=%h tstep=%0d Run=%b, required 0 0 0", ctrl, tstep, Run);
    end
    @(negedge clock);
    clear = 1'b0;
  endtask

  task automatic test_st();
    logic [41:0] exp [8];
    exp = '{F0, F1, F2, Grb | BAout | Yin, CSEout | ADDb | Zlowin, Zlowout | MARin,
            Gra | Rout | MDRin, RAMwrite};
    for (int i = 0; i < 8; i++) begin
      @(posedge clock); #1;
      checks++;
      if (ctrl !== exp[i] || tstep !== 4'(i) || Run !== 1'b1) begin
        failures++;
        $display("FAIL st step %0d: ctrl=%h tstep=%0d, required ctrl=%h tstep=%0d", i, ctrl, tstep, exp[i], i);
      end
      if (i == 0) IR = 32'h10000000;
    end
  endtask

  task automatic test_halt();
    logic [41:0] exp [4];
    exp = '{F0, F1, F2, 42'd0};
    for (int i = 0; i < 4; i++) begin
      @(posedge clock); #1;
      checks++;
      if (ctrl !== exp[i] || tstep !== 4'(i) || Run !== 1'b1) begin
        failures++;
        $display("FAIL halt step %0d: ctrl=%h tstep=%0d Run=%b, required ctrl=%h tstep=%0d Run=1", i, ctrl, tstep, Run, exp[i], i);
      end
      if (i == 0) IR = 32'hD8000000;
    end
    for (int c = 0; c < 10; c++) begin
      @(posedge clock); #1;
      checks++;
      if (ctrl !== 42'd0 || Run !== 1'b0 || tstep !== 4'd0) begin
        failures++;
        $display("FAIL halt_hold cycle %0d: ctrl=%h Run=%b tstep=%0d, required 0 0 0", c, ctrl, Run, tstep);
      end
    end
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
  endtask

  task automatic test_stop_add();
    logic [41:0] exp [6];
    exp = '{F0, F1, F2, Grb | Rout | Yin, Grc | Rout | ADDb | Zlowin, Zlowout | Gra | Rin};
    for (int i = 0; i < 6; i++) begin
      @(posedge clock); #1;
      checks++;
      if (ctrl !== exp[i] || tstep !== 4'(i) || Run !== 1'b1) begin
        failures++;
        $display("FAIL stop_add step %0d: ctrl=%h tstep=%0d Run=%b, required ctrl=%h tstep=%0d Run=1", i, ctrl, tstep, Run, exp[i], i);
      end
      if (i == 0) IR = 32'h18000000;
      if (i == 4) Stop = 1'b1;
    end
    for (int c = 0; c < 3; c++) begin
      @(posedge clock); #1;
      checks++;
      if (ctrl !== 42'd0 || Run !== 1'b0 || tstep !== 4'd0) begin
        failures++;
        $display("FAIL stop_halt cycle %0d: ctrl=%h Run=%b tstep=%0d, required 0 0 0", c, ctrl, Run, tstep);
      end
    end
    Stop = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    clear    = 1'b1;
    IR       = 32'h0;
    ConFFQ   = 1'b0;
    Stop     = 1'b0;
    test_reset();
    test_fetch_ldi();
    test_jal_jr();
    test_br();
    test_div_nop();
    test_reset_mid_ld();
    test_st();
    test_halt();
    test_stop_add();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
